// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//
// Purpose:
//   32 x WIDTH general-purpose register file. It has two combinational ALU read
//   ports (A, B), one combinational debug read port (D) and one synchronous
//   write port. Register 0 is hard-wired to zero. A 16-bit counter counts the
//   committed writes. With BYPASS=1, a write in progress is forwarded to any
//   read port that addresses the register being written.
//
// Ports:
//   Clk      in   1      system clock, rising-edge active
//   Reset_L  in   1      asynchronous active-low reset
//   RA       in   5      read-port A index
//   RB       in   5      read-port B index
//   RD       in   5      debug read-port index
//   RW       in   5      write index
//   BusW     in   WIDTH  write data
//   RegWr    in   1      write enable
//   BusA     out  WIDTH  read data A
//   BusB     out  WIDTH  read data B
//   BusD     out  WIDTH  debug read data
//   WrCount  out  16     committed-write counter (wraps)
// ---------------------------------------------------------------------------
module register_file #(
  parameter int BYPASS = 1,
  parameter int WIDTH  = 32
) (
  input  logic             Clk,
  input  logic             Reset_L,
  input  logic [4:0]       RA,
  input  logic [4:0]       RB,
  input  logic [4:0]       RD,
  input  logic [4:0]       RW,
  input  logic [WIDTH-1:0] BusW,
  input  logic             RegWr,
  output logic [WIDTH-1:0] BusA,
  output logic [WIDTH-1:0] BusB,
  output logic [WIDTH-1:0] BusD,
  output logic [15:0]      WrCount
);

  logic [WIDTH-1:0] regs [0:31];
  logic [15:0]      wr_count;
  logic             commit;

  // A write only counts when it targets a real register; index 0 is a sink.
  assign commit = RegWr && (RW != 5'd0);

  // Storage. Entry 0 is cleared by reset and is never written, so it stays
  // zero. Reads also force index 0 to zero, so entry 0 never reaches a port.
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[RW] <= BusW;
    end
  end

  // Committed-write counter. It wraps naturally at 16 bits.
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      wr_count <= '0;
    end else if (commit) begin
      wr_count <= wr_count + 16'd1;
    end
  end

  assign WrCount = wr_count;

  // One read port. Reset masks the output, so reset also blocks the bypass
  // path. The bypass path is considered only when the write will commit.
  function automatic logic [WIDTH-1:0] read_port(
    input logic [4:0]       idx,
    input logic [WIDTH-1:0] stored,
    input logic             rst_n,
    input logic             wr_commit,
    input logic [4:0]       wr_idx,
    input logic [WIDTH-1:0] wr_data
  );
    logic [WIDTH-1:0] value;
    value = stored;
    if (!rst_n || idx == 5'd0) begin
      value = '0;
    end else if (BYPASS != 0 && wr_commit && wr_idx == idx) begin
      value = wr_data;
    end
    return value;
  endfunction

  always_comb begin
    BusA = read_port(RA, regs[RA], Reset_L, commit, RW, BusW);
  end

  always_comb begin
    BusB = read_port(RB, regs[RB], Reset_L, commit, RW, BusW);
  end

  always_comb begin
    BusD = read_port(RD, regs[RD], Reset_L, commit, RW, BusW);
  end

endmodule

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
//
// Purpose:
//   Self-checking bench for register_file. It drives a BYPASS=1 instance and a
//   BYPASS=0 instance from the same stimulus. An array-based model predicts
//   every read port and the write counter of both instances. The comparison
//   runs on every falling clock edge. Hand-computed checks pin the directed
//   scenarios. A randomized phase with sporadic resets follows, and a long
//   write run exercises counter wrap.
// ---------------------------------------------------------------------------
module tb_register_file;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset_l;
  logic [4:0]       ra, rb, rd, rw;
  logic [WIDTH-1:0] bus_w;
  logic             reg_wr;

  logic [WIDTH-1:0] bus_a_byp, bus_b_byp, bus_d_byp;
  logic [WIDTH-1:0] bus_a_raw, bus_b_raw, bus_d_raw;
  logic [15:0]      wr_count_byp, wr_count_raw;

  int num_checks = 0;
  int num_errors = 0;

  always #5 clk = ~clk;

  register_file #(.BYPASS(1), .WIDTH(WIDTH)) dut_byp (
    .Clk(clk), .Reset_L(reset_l), .RA(ra), .RB(rb), .RD(rd), .RW(rw),
    .BusW(bus_w), .RegWr(reg_wr),
    .BusA(bus_a_byp), .BusB(bus_b_byp), .BusD(bus_d_byp), .WrCount(wr_count_byp)
  );

  register_file #(.BYPASS(0), .WIDTH(WIDTH)) dut_raw (
    .Clk(clk), .Reset_L(reset_l), .RA(ra), .RB(rb), .RD(rd), .RW(rw),
    .BusW(bus_w), .RegWr(reg_wr),
    .BusA(bus_a_raw), .BusB(bus_b_raw), .BusD(bus_d_raw), .WrCount(wr_count_raw)
  );

  // Reference model: a plain array and a counter.
  logic [WIDTH-1:0] model_mem [32];
  logic [15:0]      model_count;

  always @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < 32; i++) model_mem[i] = '0;
      model_count = 16'd0;
    end else if (reg_wr === 1'b1 && rw != 5'd0) begin
      model_mem[rw] = bus_w;
      model_count = model_count + 16'd1;
    end
  end

  function automatic logic [WIDTH-1:0] exp_read(input logic [4:0] idx, input bit byp);
    if (reset_l !== 1'b1 || idx == 5'd0) return '0;
    if (byp && reg_wr === 1'b1 && rw == idx) return bus_w;
    return model_mem[idx];
  endfunction

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Applies a set of inputs just after a rising edge. The inputs then stay
  // stable through the next falling edge, where the comparison samples them.
  task automatic applyStimulus(input logic wr, input logic [4:0] w,
                               input logic [WIDTH-1:0] d, input logic [4:0] a,
                               input logic [4:0] b, input logic [4:0] dd);
    @(posedge clk);
    #1;
    reg_wr = wr; rw = w; bus_w = d; ra = a; rb = b; rd = dd;
  endtask

  task automatic pulseReset();
    #2;
    reset_l = 1'b0;
    #1;
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    checkOutput("busA_byp", bus_a_byp, exp_read(ra, 1'b1));
    checkOutput("busB_byp", bus_b_byp, exp_read(rb, 1'b1));
    checkOutput("busD_byp", bus_d_byp, exp_read(rd, 1'b1));
    checkOutput("busA_raw", bus_a_raw, exp_read(ra, 1'b0));
    checkOutput("busB_raw", bus_b_raw, exp_read(rb, 1'b0));
    checkOutput("busD_raw", bus_d_raw, exp_read(rd, 1'b0));
    checkOutput("wrCount_byp", {16'd0, wr_count_byp}, {16'd0, model_count});
    checkOutput("wrCount_raw", {16'd0, wr_count_raw}, {16'd0, model_count});
  end

  initial begin
    reset_l = 1'b1; reg_wr = 1'b0; rw = 5'd0; bus_w = '0;
    ra = 5'd0; rb = 5'd0; rd = 5'd0;

    // Reset asserted mid-cycle, before any clock edge.
    #2;
    reset_l = 1'b0;
    ra = 5'd5; rb = 5'd31; rd = 5'd17;
    #1;
    checkOutput("rst_busA", bus_a_byp, 32'h0);
    checkOutput("rst_busB", bus_b_byp, 32'h0);
    checkOutput("rst_busD", bus_d_raw, 32'h0);
    checkOutput("rst_count", {16'd0, wr_count_byp}, 32'h0);

    // A write attempted while in reset is blocked and is not forwarded.
    applyStimulus(1'b1, 5'd4, 32'hCAFE0004, 5'd4, 5'd4, 5'd4);
    #1;
    checkOutput("rst_nobypass", bus_a_byp, 32'h0);
    applyStimulus(1'b0, 5'd0, '0, 5'd4, 5'd0, 5'd0);
    reset_l = 1'b1;
    #1;
    checkOutput("rst_write_lost", bus_a_byp, 32'h0);

    // The first edge after reset release accepts a write.
    applyStimulus(1'b1, 5'd7, 32'hDEADBEEF, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, '0, 5'd7, 5'd7, 5'd0);
    #1;
    checkOutput("wr_busA", bus_a_raw, 32'hDEADBEEF);
    checkOutput("wr_busB", bus_b_raw, 32'hDEADBEEF);
    checkOutput("wr_count1", {16'd0, wr_count_raw}, 32'd1);

    // A write to index 0 is discarded, even on the bypass instance.
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
    #1;
    checkOutput("zero_bypass", bus_a_byp, 32'h0);
    applyStimulus(1'b0, 5'd0, '0, 5'd0, 5'd0, 5'd0);
    #1;
    checkOutput("zero_read", bus_a_byp, 32'h0);
    checkOutput("zero_count", {16'd0, wr_count_byp}, 32'd1);

    // Same-cycle bypass against stored-value read.
    applyStimulus(1'b1, 5'd3, 32'h11, 5'd0, 5'd0, 5'd0);
    applyStimulus(1'b1, 5'd3, 32'h22, 5'd3, 5'd3, 5'd3);
    #1;
    checkOutput("byp1_busA", bus_a_byp, 32'h22);
    checkOutput("byp1_busD", bus_d_byp, 32'h22);
    checkOutput("byp0_busA", bus_a_raw, 32'h11);
    checkOutput("byp0_busB", bus_b_raw, 32'h11);
    applyStimulus(1'b0, 5'd0, '0, 5'd3, 5'd0, 5'd0);
    #1;
    checkOutput("after_byp1", bus_a_byp, 32'h22);
    checkOutput("after_byp0", bus_a_raw, 32'h22);

    // Fill all registers starting from a clean reset, then sweep the debug port.
    pulseReset();
    applyStimulus(1'b0, 5'd0, '0, 5'd0, 5'd0, 5'd0);
    reset_l = 1'b1;
    for (int i = 1; i < 32; i++) begin
      applyStimulus(1'b1, 5'(i), 32'h100 + i, 5'd0, 5'd0, 5'd0);
    end
    applyStimulus(1'b0, 5'd0, '0, 5'd0, 5'd0, 5'd0);
    #1;
    checkOutput("fill_count", {16'd0, wr_count_byp}, 32'd31);
    for (int i = 0; i < 32; i++) begin
      rd = 5'(i);
      #1;
      checkOutput("sweep_busD", bus_d_raw, (i == 0) ? 32'h0 : 32'h100 + i);
    end

    // Asynchronous reset mid-run clears everything at once.
    ra = 5'd5; rb = 5'd31; rd = 5'd17;
    #1;
    checkOutput("pre_rst_busB", bus_b_byp, 32'h11F);
    pulseReset();
    checkOutput("midrst_busA", bus_a_byp, 32'h0);
    checkOutput("midrst_busB", bus_b_raw, 32'h0);
    checkOutput("midrst_busD", bus_d_byp, 32'h0);
    checkOutput("midrst_count", {16'd0, wr_count_raw}, 32'd0);
    applyStimulus(1'b0, 5'd0, '0, 5'd0, 5'd0, 5'd0);
    reset_l = 1'b1;

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                    5'($urandom), 5'($urandom), 5'($urandom));
      if ($urandom_range(0, 99) == 0) reset_l = 1'b0;
      else reset_l = 1'b1;
    end
    applyStimulus(1'b0, 5'd0, '0, 5'd0, 5'd0, 5'd0);
    reset_l = 1'b1;

    // Counter wrap: exactly 65536 committed writes after a reset.
    pulseReset();
    applyStimulus(1'b0, 5'd0, '0, 5'd0, 5'd0, 5'd0);
    reset_l = 1'b1;
    for (int n = 0; n < 65536; n++) begin
      applyStimulus(1'b1, 5'($urandom_range(1, 31)), $urandom,
                    5'($urandom), 5'($urandom), 5'($urandom));
    end
    applyStimulus(1'b0, 5'd0, '0, 5'd0, 5'd0, 5'd0);
    #1;
    checkOutput("wrap_count", {16'd0, wr_count_byp}, 32'd0);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL provide parameter BYPASS, default 1, meaning: 1 = a same-cycle write is visible on read ports, 0 = read ports always return stored contents.
REQ-002 The block SHALL provide parameter WIDTH, default 32, meaning: data width of every register and bus.
REQ-003 Port Clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port Reset_L  input  1  reset; asynchronous, active-low.
REQ-005 Port RA  input  5  read-port A register index.
REQ-006 Port RB  input  5  read-port B register index.
REQ-007 Port RD  input  5  debug read-port index, for bench observation.
REQ-008 Port RW  input  5  write register index.
REQ-009 Port BusW  input  WIDTH  write data, which carries the ALU result.
REQ-010 Port RegWr  input  1  write enable, sampled at the rising Clk edge.
REQ-011 Port BusA  output  WIDTH  read data A, which feeds ALU operand A.
REQ-012 Port BusB  output  WIDTH  read data B, which feeds ALU operand B.
REQ-013 Port BusD  output  WIDTH  debug read data.
REQ-014 Port WrCount  output  16  count of committed writes.

Function
REQ-015 The block SHALL contain 32 registers of WIDTH bits, indexed 0..31.
REQ-016 Register 0 SHALL read as 0 on every read port at all times; a write to index 0 SHALL be discarded and SHALL NOT increment WrCount.
REQ-017 On a rising Clk edge with RegWr=1 and RW!=0, register[RW] SHALL take BusW, and the stored value SHALL be visible in the next cycle; the write latency is 1 cycle.
REQ-018 With RegWr=0, no register SHALL change.
REQ-019 Reads SHALL be combinational, with zero latency from any change of RA, RB or RD.
REQ-020 With BYPASS=1, RegWr=1 and RW!=0, a read index equal to RW SHALL return BusW in the same cycle; all three read ports SHALL bypass independently.
REQ-021 With BYPASS=0, every read SHALL return the stored value, so the pre-write value is returned in the write cycle.
REQ-022 RA, RB and RD MAY be equal to each other or to RW, and every port SHALL return the correct value.
REQ-023 WrCount SHALL increment by 1 on each committed write (RegWr=1, RW!=0) and SHALL wrap from 16'hFFFF to 0.
REQ-024 No X SHALL propagate from unwritten registers; every register is defined from reset.
REQ-025 An X on RegWr or RW SHALL NOT be masked silently; behaviour is left to the simulator, and the bench SHALL NOT drive X on them.

Reset
REQ-026 Reset_L=0 SHALL immediately, without waiting for Clk, force all 32 registers to 0 and WrCount to 0, so that BusA, BusB and BusD read 0.
REQ-027 While Reset_L=0, writes SHALL be blocked, and BYPASS SHALL be disabled so that the read ports output 0.
REQ-028 If reset is asserted in the same cycle as a write, the write SHALL be lost.
REQ-029 After Reset_L deasserts, the first rising Clk edge SHALL accept writes.

Verification
REQ-030 Reset then read: Reset_L=0 mid-cycle, then RA=5, RB=31, RD=17 -> BusA=BusB=BusD=0 with no clock edge needed, and WrCount=0.
REQ-031 Write then read: write 32'hDEADBEEF to reg 7; next cycle RA=7, RB=7 -> BusA=BusB=32'hDEADBEEF, and WrCount=1.
REQ-032 Zero register: RegWr=1, RW=0, BusW=32'hFFFFFFFF -> RA=0 reads 0, and WrCount is unchanged.
REQ-033 Same-cycle bypass: reg 3 holds 32'h11; write 32'h22 to reg 3 with RA=3 -> BusA=32'h22 in that cycle when BYPASS=1, and 32'h11 when BYPASS=0; the next cycle reads 32'h22 in both cases.
REQ-034 All registers: write 32'h100+i to reg i for i=1..31, then sweep RD over 0..31 -> BusD=0 for index 0 and 32'h100+i otherwise, and WrCount=31.
REQ-035 Async reset mid-run: after REQ-034, pulse Reset_L low between clock edges -> every read returns 0 immediately, and WrCount=0.
